ram_ctrl: RTL and testbench

//  Single-port word memory with programmable wait states. Sits directly downstream of the

---
 rtl/ram_ctrl.sv | 111 +++++++++++
 tb/tb_ram_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// Single-port 32-bit word memory with a fixed number of wait states per access.
// Exposes the controller state on state_o so the access sequence can be observed directly.
module ram_ctrl #(
    parameter int    ADDR_W    = 10,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        Ren,
    input  logic        Wen,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic        busy_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [31:0]       mem [DEPTH];

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       data_q, data_d;
    logic              wr_q, wr_d;
    logic [31:0]       ramload_q, ramload_d;
    logic              mem_we;
    logic              req;

    // Byte-offset bits and bits above the word index are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{ramaddr[31:ADDR_W+2], ramaddr[1:0]};

    // Handshake: the requester holds Ren/Wen while busy_o=1; busy_o=0 with a request
    // outstanding means the access completed this cycle (DONE) and ramload is valid for reads.
    always_comb begin
        req       = Ren | Wen;
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        wr_d      = wr_q;
        ramload_d = ramload_q;
        mem_we    = 1'b0;
        busy_o    = 1'b0;
        case (state_q)
            IDLE: begin
                busy_o = req;
                if (req) begin
                    idx_d   = ramaddr[ADDR_W+1:2];
                    data_d  = ramstore;
                    wr_d    = Wen;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                busy_o = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (wr_q) mem_we = 1'b1;
                    else      ramload_d = mem[idx_q];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            data_q    <= 32'h0;
            wr_q      <= 1'b0;
            ramload_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            ramload_q <= ramload_d;
        end
    end

    // The array has no reset; a write only lands when WAIT completes.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[idx_q] <= data_q;
    end

    assign ramload = ramload_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: four instances cover default geometry, a 4-bit index,
// and the LATENCY extremes 1 and 15.
module tb_ram_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic             clk;
    logic             rst_n;
    logic [3:0]       ren;
    logic [3:0]       wen;
    logic [3:0][31:0] addr;
    logic [3:0][31:0] store;
    logic [3:0][31:0] load;
    logic [3:0]       busy;
    logic [3:0][1:0]  st;

    int n_checks;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_ctrl #(.ADDR_W(10), .LATENCY(2)) u_main (
        .CLK(clk), .nRST(rst_n), .Ren(ren[0]), .Wen(wen[0]), .ramaddr(addr[0]),
        .ramstore(store[0]), .ramload(load[0]), .busy_o(busy[0]), .state_o(st[0])
    );
    ram_ctrl #(.ADDR_W(4), .LATENCY(2)) u_wrap (
        .CLK(clk), .nRST(rst_n), .Ren(ren[1]), .Wen(wen[1]), .ramaddr(addr[1]),
        .ramstore(store[1]), .ramload(load[1]), .busy_o(busy[1]), .state_o(st[1])
    );
    ram_ctrl #(.ADDR_W(10), .LATENCY(1)) u_lat1 (
        .CLK(clk), .nRST(rst_n), .Ren(ren[2]), .Wen(wen[2]), .ramaddr(addr[2]),
        .ramstore(store[2]), .ramload(load[2]), .busy_o(busy[2]), .state_o(st[2])
    );
    ram_ctrl #(.ADDR_W(10), .LATENCY(15)) u_lat15 (
        .CLK(clk), .nRST(rst_n), .Ren(ren[3]), .Wen(wen[3]), .ramaddr(addr[3]),
        .ramstore(store[3]), .ramload(load[3]), .busy_o(busy[3]), .state_o(st[3])
    );

    // Drives one access on instance k and holds the request until busy drops (bounded).
    // bw = number of cycles busy was seen high; ld = ramload in the DONE cycle.
    // With chg set, addr/store are replaced by ca/cd one cycle into the access.
    task automatic access(input int k, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit chg, input logic [31:0] ca, input logic [31:0] cd,
                          output int bw, output logic [31:0] ld);
        @(negedge clk);
        ren[k] = r; wen[k] = w; addr[k] = a; store[k] = d;
        #1;
        bw = 0;
        while (busy[k] === 1'b1 && bw < 40) begin
            bw++;
            @(negedge clk);
            if (chg && bw == 1) begin
                addr[k] = ca; store[k] = cd;
            end
            #1;
        end
        ld = load[k];
        ren[k] = 1'b0; wen[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        for (int k = 0; k < 4; k++) begin
            ren[k] = 1'b0; wen[k] = 1'b0; addr[k] = 32'h0; store[k] = 32'h0;
        end
        rst_n  = 1'b0;
        ren[0] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (load[0] !== 32'h0) $display("FAIL reset_ramload: got %h expected %h", load[0], 32'h0);
        else n_pass++;
        n_checks++;
        if (st[0] !== S_IDLE) $display("FAIL reset_state: got %0d expected %0d", st[0], S_IDLE);
        else n_pass++;
        ren[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (busy[0] !== 1'b0) $display("FAIL reset_busy_idle: got %b expected 0", busy[0]);
        else n_pass++;
        n_checks++;
        if (st[0] !== S_IDLE) $display("FAIL reset_state_after: got %0d expected %0d", st[0], S_IDLE);
        else n_pass++;
    endtask

    task automatic test_write_read;
        int bw;
        logic [31:0] ld;
        access(0, 1'b0, 1'b1, 32'h10, 32'h12341234, 1'b0, 32'h0, 32'h0, bw, ld);
        n_checks++;
        if (bw !== 3) $display("FAIL wr_busy_width: got %0d expected 3", bw);
        else n_pass++;
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0, bw, ld);
        n_checks++;
        if (bw !== 3) $display("FAIL rd_busy_width: got %0d expected 3", bw);
        else n_pass++;
        n_checks++;
        if (ld !== 32'h12341234) $display("FAIL rd_data_10: got %h expected %h", ld, 32'h12341234);
        else n_pass++;
    endtask

    task automatic test_mid_access;
        int bw;
        logic [31:0] ld;
        access(0, 1'b0, 1'b1, 32'h24, 32'h24242424, 1'b0, 32'h0, 32'h0, bw, ld);
        access(0, 1'b0, 1'b1, 32'h20, 32'hABCDABCD, 1'b1, 32'h24, 32'h0, bw, ld);
        n_checks++;
        if (bw !== 3) $display("FAIL mid_busy_width: got %0d expected 3", bw);
        else n_pass++;
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 32'h0, bw, ld);
        n_checks++;
        if (ld !== 32'hABCDABCD) $display("FAIL mid_rd_20: got %h expected %h", ld, 32'hABCDABCD);
        else n_pass++;
        access(0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h0, 32'h0, bw, ld);
        n_checks++;
        if (ld !== 32'h24242424) $display("FAIL mid_rd_24: got %h expected %h", ld, 32'h24242424);
        else n_pass++;
    endtask

    task automatic test_wrap;
        int bw;
        logic [31:0] ld;
        access(1, 1'b0, 1'b1, 32'h1C, 32'h77777777, 1'b0, 32'h0, 32'h0, bw, ld);
        access(1, 1'b0, 1'b1, 32'h43, 32'h33333333, 1'b0, 32'h0, 32'h0, bw, ld);
        access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, bw, ld);
        n_checks++;
        if (ld !== 32'h33333333) $display("FAIL wrap_rd_0: got %h expected %h", ld, 32'h33333333);
        else n_pass++;
        access(1, 1'b1, 1'b0, 32'hFFFF_FF82, 32'h0, 1'b0, 32'h0, 32'h0, bw, ld);
        n_checks++;
        if (ld !== 32'h33333333) $display("FAIL wrap_rd_high: got %h expected %h", ld, 32'h33333333);
        else n_pass++;
        access(1, 1'b1, 1'b0, 32'h5D, 32'h0, 1'b0, 32'h0, 32'h0, bw, ld);
        n_checks++;
        if (ld !== 32'h77777777) $display("FAIL wrap_rd_idx7: got %h expected %h", ld, 32'h77777777);
        else n_pass++;
    endtask

    task automatic test_ren_wen;
        int bw;
        logic [31:0] ld;
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0, bw, ld);
        n_checks++;
        if (ld !== 32'h12341234) $display("FAIL rw_pre_read: got %h expected %h", ld, 32'h12341234);
        else n_pass++;
        access(0, 1'b1, 1'b1, 32'h8, 32'h22222222, 1'b0, 32'h0, 32'h0, bw, ld);
        n_checks++;
        if (bw !== 3) $display("FAIL rw_busy_width: got %0d expected 3", bw);
        else n_pass++;
        n_checks++;
        if (ld !== 32'h12341234) $display("FAIL rw_ramload_held: got %h expected %h", ld, 32'h12341234);
        else n_pass++;
        access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0, 32'h0, bw, ld);
        n_checks++;
        if (ld !== 32'h22222222) $display("FAIL rw_rd_8: got %h expected %h", ld, 32'h22222222);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        bit         exp_b [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0] exp_s [5] = '{S_IDLE, S_WAIT, S_WAIT, S_DONE, S_IDLE};
        @(negedge clk);
        ren[0] = 1'b1; addr[0] = 32'h20;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (busy[0] !== exp_b[i]) $display("FAIL b2b_busy_c%0d: got %b expected %b", i, busy[0], exp_b[i]);
            else n_pass++;
            n_checks++;
            if (st[0] !== exp_s[i]) $display("FAIL b2b_state_c%0d: got %0d expected %0d", i, st[0], exp_s[i]);
            else n_pass++;
            if (i < 4) @(negedge clk);
        end
        ren[0] = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (st[0] !== S_IDLE) $display("FAIL b2b_no_restart: got %0d expected %0d", st[0], S_IDLE);
        else n_pass++;
        n_checks++;
        if (load[0] !== 32'hABCDABCD) $display("FAIL b2b_ramload: got %h expected %h", load[0], 32'hABCDABCD);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait;
        int bw;
        logic [31:0] ld;
        access(0, 1'b0, 1'b1, 32'h30, 32'h11111111, 1'b0, 32'h0, 32'h0, bw, ld);
        @(negedge clk);
        wen[0] = 1'b1; addr[0] = 32'h30; store[0] = 32'h55555555;
        @(negedge clk);
        #1;
        n_checks++;
        if (st[0] !== S_WAIT) $display("FAIL rst_in_wait: got %0d expected %0d", st[0], S_WAIT);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (st[0] !== S_IDLE) $display("FAIL rst_async_state: got %0d expected %0d", st[0], S_IDLE);
        else n_pass++;
        n_checks++;
        if (load[0] !== 32'h0) $display("FAIL rst_async_ramload: got %h expected %h", load[0], 32'h0);
        else n_pass++;
        wen[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0, 32'h0, bw, ld);
        n_checks++;
        if (ld !== 32'h11111111) $display("FAIL rst_aborted_write: got %h expected %h", ld, 32'h11111111);
        else n_pass++;
    endtask

    task automatic test_latency;
        int bw;
        int lat;
        logic [31:0] ld;
        logic [31:0] dat;
        for (int k = 2; k < 4; k++) begin
            lat = (k == 2) ? 1 : 15;
            dat = (k == 2) ? 32'hA5A50001 : 32'h5A5A000F;
            access(k, 1'b0, 1'b1, 32'h100, dat, 1'b0, 32'h0, 32'h0, bw, ld);
            n_checks++;
            if (bw !== lat + 1) $display("FAIL lat%0d_wr_busy: got %0d expected %0d", lat, bw, lat + 1);
            else n_pass++;
            access(k, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0, bw, ld);
            n_checks++;
            if (bw !== lat + 1) $display("FAIL lat%0d_rd_busy: got %0d expected %0d", lat, bw, lat + 1);
            else n_pass++;
            n_checks++;
            if (ld !== dat) $display("FAIL lat%0d_rd_data: got %h expected %h", lat, ld, dat);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_write_read();
        test_mid_access();
        test_wrap();
        test_ren_wen();
        test_back_to_back();
        test_reset_mid_wait();
        test_latency();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
